conway_frame_reader: RTL and testbench
======================================

# conway_frame_reader

Reads the Game of Life board. It snapshots the flattened `state_q` vector of all `conway_cell` instances and streams it out one row at a time over a valid/ready interface to a display or host link. After every `FRAMES_PER_GEN` complete frames it issues a one-cycle `step` pulse, which advances the board one generation. It sits between the cell array and the output driver, and it is the only block that paces generation advance.

## Interface
- `ROWS`, 8, board height in cells (≥2)
- `COLS`, 8, board width in cells (≥1)
- `FRAMES_PER_GEN`, 2, frames streamed per generation (≥1)
- `clk`  in  1  sole clock, all logic on posedge
- `rst`  in  1  reset; asynchronous, active-low (asserted when 0)
- `ena`  in  1  run enable; high lets new frames start
- `board`  in  ROWS*COLS  cell states; cell (r,c) at bit r*COLS+c
- `row_data`  out  COLS  snapshot row; bit c = cell (row_idx,c)
- `row_idx`  out  $clog2(ROWS)  index of the row on `row_data`
- `row_valid`  out  1  row beat valid
- `row_ready`  in  1  sink accepts beat
- `frame_done`  out  1  one-cycle pulse when the last row is accepted
- `step`  out  1  one-cycle generation-advance pulse to the cell array

## Operation
- States: IDLE, CAPTURE, SEND, STEP, SETTLE.
- IDLE
  - `ena`=1 → CAPTURE next cycle.
  - `ena`=0 → stay.
- CAPTURE
  - Registers `board` into an internal shadow of ROWS*COLS bits.
  - Sets row counter to 0.
  - → SEND.
- SEND
  - `row_valid`=1, `row_data`=shadow row at row counter, `row_idx`=row counter.
  - Beat transfers on a cycle with `row_valid`&`row_ready`.
  - Transfer of row <ROWS-1: counter +1, next row presented the following cycle.
  - Transfer of row ROWS-1: `frame_done` pulses the next cycle; the frame counter then either increments or wraps.
  - If frame counter == FRAMES_PER_GEN-1: counter wraps to 0, → STEP.
  - Otherwise: counter +1, → IDLE.
- STEP
  - `step`=1 for exactly one cycle → SETTLE.
- SETTLE
  - One idle cycle so the cells' new `state_q` is stable on `board` → IDLE.
- `ena` is sampled only in IDLE. A frame in progress always completes, including any STEP/SETTLE, even if `ena` drops.
- The shadow is frozen from CAPTURE until the next CAPTURE. Changes on `board` during SEND do not affect streamed data.
- Frame counter width: $clog2(FRAMES_PER_GEN) with a minimum of 1. It wraps at FRAMES_PER_GEN-1, never at a power of two.
- FRAMES_PER_GEN=1: every frame ends in STEP.

## Timing
- All outputs are registered. Reset values:
  - `row_valid`=0, `row_data`=0, `row_idx`=0
  - `frame_done`=0, `step`=0
  - state IDLE, row and frame counters 0, shadow 0
- Reset asserts asynchronously and clears all state immediately. Deassertion is synchronous with respect to the first valid edge (a synchronizer sits upstream).
- Latency:
  - `ena` high in IDLE → first `row_valid` 2 cycles later (IDLE→CAPTURE→SEND).
  - With `row_ready` held high, a frame takes ROWS cycles in SEND.
  - Frame start to frame start: ROWS+2 cycles without step, ROWS+4 with step.
- Handshake:
  - Once `row_valid` rises, `row_data`/`row_idx` hold stable until the transfer.
  - `row_valid` never drops without a transfer.
  - `row_valid` is 0 in all states other than SEND.
- `frame_done` and `step` never assert in the same cycle. `step` follows `frame_done` by 1 cycle.
- Reset mid-SEND aborts the frame. No `frame_done` or `step` is produced.

## Structure
- `conway_pkg` holds:
  - the `reader_state_t` enum (IDLE, CAPTURE, SEND, STEP, SETTLE)
  - the board index helper constant functions, so `conway_board` uses the same r*COLS+c mapping
- No sub-module. The row mux is an indexed part-select of the shadow. The counters are inline.

## Test plan
- Reset and idle: `rst`=0 then 1, `ena`=0 for 20 cycles → all outputs 0 throughout.
- Basic frame, ROWS=COLS=4, FRAMES_PER_GEN=1, `board`=16'hA5C3, `row_ready`=1:
  - (row_idx,row_data) = (0,3),(1,C),(2,5),(3,A) on consecutive cycles
  - `frame_done` the cycle after row 3
  - `step` one cycle after `frame_done`
- Backpressure: `row_ready`=0 for 5 cycles on row 1 → `row_data`/`row_idx` constant and `row_valid`=1 for all 5 cycles. Row 2 appears 1 cycle after `row_ready` rises.
- Snapshot isolation: flip `board` to all-ones mid-SEND → remaining rows still show the captured pattern. The next frame shows all-ones.
- Step pacing, FRAMES_PER_GEN=3, `ena` held → exactly one `step` per 3 `frame_done` pulses over 9 frames.
- Disable and reset mid-frame:
  - `ena`→0 at row 1 → the frame completes, then IDLE with no further `row_valid`.
  - Separately, `rst`=0 at row 2 → `row_valid` drops at once, with no `frame_done` and no `step`.

Source files
------------

// File: rtl/conway_pkg.sv
// Shared Game of Life definitions: frame reader FSM states and board index mapping.
// Cell (r,c) lives at flat bit r*COLS+c. The board and the reader both use these
// helpers, so the two sides always agree on the layout.
package conway_pkg;

    // Frame reader sequencing states
    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SEND,
        STEP,
        SETTLE
    } reader_state_t;

    // Flat bit index of cell (r,c) on a board that is cols cells wide
    function automatic int cell_index(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

    // Flat bit index of the first cell of row r
    function automatic int row_base(input int r, input int cols);
        return cell_index(r, 0, cols);
    endfunction

endpackage

// File: rtl/conway_frame_reader.sv
// Snapshots the Game of Life board and streams it out one row per beat, then paces generation steps.
// Latency: ena seen in IDLE -> first row_valid 2 cycles later; ROWS beats per frame with ready held high.
// Backpressure: row beats hold stable while row_ready is low; a generation step only follows a completed frame.
module conway_frame_reader
    import conway_pkg::*;
#(
    parameter int ROWS           = 8,
    parameter int COLS           = 8,
    parameter int FRAMES_PER_GEN = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_ena,
    input  logic [ROWS*COLS-1:0]     i_board,
    output logic [COLS-1:0]          o_row_data,
    output logic [$clog2(ROWS)-1:0]  o_row_idx,
    output logic                     o_row_valid,
    input  logic                     i_row_ready,
    output logic                     o_frame_done,
    output logic                     o_step
);

    localparam int RW = $clog2(ROWS);
    localparam int FW = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
    localparam int BW = $clog2(ROWS * COLS);

    localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'(FRAMES_PER_GEN - 1);

    reader_state_t          r_state;
    logic [ROWS*COLS-1:0]   r_shadow;
    logic [RW-1:0]          r_row_cnt;
    logic [FW-1:0]          r_frame_cnt;
    logic [COLS-1:0]        r_row_data;
    logic [RW-1:0]          r_row_idx;
    logic                   r_row_valid;
    logic                   r_frame_done;
    logic                   r_step;

    logic [RW-1:0]          w_next_row;
    logic [BW-1:0]          w_next_base;
    logic                   w_xfer;

    assign w_next_row = r_row_cnt + RW'(1);
    assign w_xfer     = r_row_valid & i_row_ready;

    // Bit offset of the row that follows the one currently presented
    always_comb begin
        w_next_base = BW'(row_base(int'(w_next_row), COLS));
    end

    // Reader FSM: capture, row streaming, frame counting and step pacing, all outputs registered
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= IDLE;
            r_shadow     <= '0;
            r_row_cnt    <= '0;
            r_frame_cnt  <= '0;
            r_row_data   <= '0;
            r_row_idx    <= '0;
            r_row_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_step       <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_step       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_ena) begin
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // Row 0 comes straight from the board since the shadow loads on this same edge
                    r_shadow    <= i_board;
                    r_row_cnt   <= '0;
                    r_row_idx   <= '0;
                    r_row_data  <= i_board[COLS-1:0];
                    r_row_valid <= 1'b1;
                    r_state     <= SEND;
                end
                SEND: begin
                    if (w_xfer) begin
                        if (r_row_cnt != LAST_ROW) begin
                            r_row_cnt  <= w_next_row;
                            r_row_idx  <= w_next_row;
                            r_row_data <= r_shadow[w_next_base +: COLS];
                        end else begin
                            r_row_valid  <= 1'b0;
                            r_row_idx    <= '0;
                            r_row_data   <= '0;
                            r_row_cnt    <= '0;
                            r_frame_done <= 1'b1;
                            if (r_frame_cnt == LAST_FRAME) begin
                                r_frame_cnt <= '0;
                                r_state     <= STEP;
                            end else begin
                                r_frame_cnt <= r_frame_cnt + FW'(1);
                                r_state     <= IDLE;
                            end
                        end
                    end
                end
                STEP: begin
                    // Registered, so the pulse lands one cycle after frame_done
                    r_step  <= 1'b1;
                    r_state <= SETTLE;
                end
                SETTLE: begin
                    // Gives the cells a cycle to present their new generation on the board
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_row_data   = r_row_data;
    assign o_row_idx    = r_row_idx;
    assign o_row_valid  = r_row_valid;
    assign o_frame_done = r_frame_done;
    assign o_step       = r_step;

endmodule

// File: tb/tb_conway_frame_reader.sv
// Directed bench for conway_frame_reader: two 4x4 instances, one stepping every frame, one every third frame.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
// Every comparison is an immediate assertion that counts and reports its failure.
module tb_conway_frame_reader;

    logic        clk;
    logic        rst_a, rst_b;
    logic        ena_a, ena_b;
    logic        rdy_a, rdy_b;
    logic [15:0] board_a, board_b;

    logic [3:0]  data_a, data_b;
    logic [1:0]  idx_a, idx_b;
    logic        vld_a, vld_b;
    logic        fd_a, fd_b;
    logic        step_a, step_b;

    int n_checks = 0;
    int n_err    = 0;

    conway_frame_reader #(.ROWS(4), .COLS(4), .FRAMES_PER_GEN(1)) dut_a (
        .i_clk        (clk),
        .i_rst        (rst_a),
        .i_ena        (ena_a),
        .i_board      (board_a),
        .o_row_data   (data_a),
        .o_row_idx    (idx_a),
        .o_row_valid  (vld_a),
        .i_row_ready  (rdy_a),
        .o_frame_done (fd_a),
        .o_step       (step_a)
    );

    conway_frame_reader #(.ROWS(4), .COLS(4), .FRAMES_PER_GEN(3)) dut_b (
        .i_clk        (clk),
        .i_rst        (rst_b),
        .i_ena        (ena_b),
        .i_board      (board_b),
        .o_row_data   (data_b),
        .o_row_idx    (idx_b),
        .o_row_valid  (vld_b),
        .i_row_ready  (rdy_b),
        .o_frame_done (fd_b),
        .o_step       (step_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compares dut_a outputs packed as {valid, frame_done, step, idx[1:0], data[3:0]}
    task automatic chk_a(input string tag, input logic v, input logic fd, input logic st,
                         input logic [1:0] idx, input logic [3:0] dat);
        chk(tag, {23'd0, vld_a, fd_a, step_a, idx_a, data_a},
                 {23'd0, v, fd, st, idx, dat});
    endtask

    int   fd_cnt;
    int   step_cnt;
    logic prev_fd;

    initial begin
        rst_a   = 1'b0; rst_b = 1'b0;
        ena_a   = 1'b0; ena_b = 1'b0;
        rdy_a   = 1'b1; rdy_b = 1'b1;
        board_a = 16'hA5C3;
        board_b = 16'h1234;
        #2;
        chk_a("reset_outputs", 0, 0, 0, 2'd0, 4'h0);
        cyc; cyc;
        rst_a = 1'b1; rst_b = 1'b1;

        // Idle with ena low: nothing moves
        for (int i = 0; i < 20; i++) begin
            cyc;
            chk_a("idle_quiet", 0, 0, 0, 2'd0, 4'h0);
        end

        // Basic frame, board A5C3 -> rows 3,C,5,A
        ena_a = 1'b1;
        cyc; chk_a("capture_no_valid", 0, 0, 0, 2'd0, 4'h0);
        ena_a = 1'b0;
        cyc; chk_a("basic_row0", 1, 0, 0, 2'd0, 4'h3);
        cyc; chk_a("basic_row1", 1, 0, 0, 2'd1, 4'hC);
        cyc; chk_a("basic_row2", 1, 0, 0, 2'd2, 4'h5);
        cyc; chk_a("basic_row3", 1, 0, 0, 2'd3, 4'hA);
        cyc; chk_a("basic_frame_done", 0, 1, 0, 2'd0, 4'h0);
        cyc; chk_a("basic_step", 0, 0, 1, 2'd0, 4'h0);
        cyc; chk_a("basic_settle", 0, 0, 0, 2'd0, 4'h0);
        cyc; chk_a("basic_back_idle", 0, 0, 0, 2'd0, 4'h0);

        // Backpressure on row 1 for 5 cycles
        ena_a = 1'b1;
        cyc;
        ena_a = 1'b0;
        cyc; chk_a("bp_row0", 1, 0, 0, 2'd0, 4'h3);
        cyc; chk_a("bp_row1", 1, 0, 0, 2'd1, 4'hC);
        rdy_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc;
            chk_a("bp_row1_hold", 1, 0, 0, 2'd1, 4'hC);
        end
        rdy_a = 1'b1;
        cyc; chk_a("bp_row2", 1, 0, 0, 2'd2, 4'h5);
        cyc; chk_a("bp_row3", 1, 0, 0, 2'd3, 4'hA);
        cyc; chk_a("bp_frame_done", 0, 1, 0, 2'd0, 4'h0);
        cyc; chk_a("bp_step", 0, 0, 1, 2'd0, 4'h0);
        cyc;

        // Snapshot isolation: board changes mid-frame
        ena_a = 1'b1;
        cyc;
        ena_a = 1'b0;
        cyc; chk_a("snap_row0", 1, 0, 0, 2'd0, 4'h3);
        cyc; chk_a("snap_row1", 1, 0, 0, 2'd1, 4'hC);
        board_a = 16'hFFFF;
        cyc; chk_a("snap_row2_old", 1, 0, 0, 2'd2, 4'h5);
        cyc; chk_a("snap_row3_old", 1, 0, 0, 2'd3, 4'hA);
        cyc; chk_a("snap_frame_done", 0, 1, 0, 2'd0, 4'h0);
        cyc; cyc;
        ena_a = 1'b1;
        cyc;
        ena_a = 1'b0;
        cyc; chk_a("snap_new_row0", 1, 0, 0, 2'd0, 4'hF);
        cyc; chk_a("snap_new_row1", 1, 0, 0, 2'd1, 4'hF);
        cyc; chk_a("snap_new_row2", 1, 0, 0, 2'd2, 4'hF);
        cyc; chk_a("snap_new_row3", 1, 0, 0, 2'd3, 4'hF);
        cyc; chk_a("snap_new_frame_done", 0, 1, 0, 2'd0, 4'h0);
        cyc; chk_a("snap_new_step", 0, 0, 1, 2'd0, 4'h0);
        cyc;

        // Disable mid-frame: frame completes, then no more beats
        board_a = 16'hA5C3;
        ena_a   = 1'b1;
        cyc;
        cyc; chk_a("dis_row0", 1, 0, 0, 2'd0, 4'h3);
        cyc; chk_a("dis_row1", 1, 0, 0, 2'd1, 4'hC);
        ena_a = 1'b0;
        cyc; chk_a("dis_row2", 1, 0, 0, 2'd2, 4'h5);
        cyc; chk_a("dis_row3", 1, 0, 0, 2'd3, 4'hA);
        cyc; chk_a("dis_frame_done", 0, 1, 0, 2'd0, 4'h0);
        cyc; chk_a("dis_step", 0, 0, 1, 2'd0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            cyc;
            chk_a("dis_stays_idle", 0, 0, 0, 2'd0, 4'h0);
        end

        // Reset mid-frame at row 2: immediate abort, no frame_done or step
        ena_a = 1'b1;
        cyc;
        ena_a = 1'b0;
        cyc; cyc;
        cyc; chk_a("rst_pre_row2", 1, 0, 0, 2'd2, 4'h5);
        rst_a = 1'b0;
        #1;
        chk_a("rst_async_drop", 0, 0, 0, 2'd0, 4'h0);
        for (int i = 0; i < 2; i++) begin
            cyc;
            chk_a("rst_held", 0, 0, 0, 2'd0, 4'h0);
        end
        rst_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc;
            chk_a("rst_after_release", 0, 0, 0, 2'd0, 4'h0);
        end

        // Step pacing on dut_b: 9 frames, a step after every third frame_done
        fd_cnt   = 0;
        step_cnt = 0;
        prev_fd  = 1'b0;
        ena_b    = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cyc;
            chk("pace_fd_step_exclusive", {31'd0, fd_b & step_b}, 32'd0);
            if (step_b) begin
                step_cnt++;
                chk("pace_step_position", {30'd0, prev_fd, 1'b0} | (fd_cnt % 3 != 0 ? 32'd1 : 32'd0),
                    32'd2);
            end
            if (fd_b) fd_cnt++;
            prev_fd = fd_b;
        end
        ena_b = 1'b0;
        chk("pace_frame_count", fd_cnt, 32'd9);
        chk("pace_step_count", step_cnt, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
